can_frame_tracker: RTL and testbench

Bit-level CAN 2.0 frame sequencer that sits directly upstream of the EOF error checker. On every sample-point strobe it removes stuff bits, tracks the current frame field (SOF through intermission), checks stuffing and the fixed-form delimiters, and drives the active-low `EOF_Flag` window that the EOF checker consumes. Destuffed bits are also presented for downstream CRC and field-capture logic.

---
 rtl/can_pkg.sv | 23 ++
 rtl/can_frame_tracker_if.sv | 21 ++
 rtl/can_bit_destuff.sv | 26 ++
 rtl/can_frame_tracker.sv | 112 +++++++++++
 tb/tb_can_frame_tracker.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/can_pkg.sv
// can_pkg: CAN field codes, fixed field lengths and the per-field bit-length lookup
package can_pkg;
  typedef enum logic [4:0] {
    WAIT_IDLE, IDLE, SOF, ID_A, SRR_RTR, IDE, ID_B, RTR_EXT, R1, R0,
    DLC, DATA, CRC, CRC_DEL, ACK, ACK_DEL, EOF, INTERMISSION
  } field_e;
  localparam int ID_A_LEN         = 11;
  localparam int ID_B_LEN         = 18;
  localparam int DLC_LEN          = 4;
  localparam int CRC_LEN          = 15;
  localparam int EOF_LEN          = 7;
  localparam int INTERMISSION_LEN = 3;
  localparam int MAX_DATA_BITS    = 64;
  function automatic logic [6:0] field_len(input field_e f, input logic [6:0] data_bits);
    return f == ID_A         ? 7'(ID_A_LEN) :
           f == ID_B         ? 7'(ID_B_LEN) :
           f == DLC          ? 7'(DLC_LEN) :
           f == DATA         ? data_bits :
           f == CRC          ? 7'(CRC_LEN) :
           f == EOF          ? 7'(EOF_LEN) :
           f == INTERMISSION ? 7'(INTERMISSION_LEN) : 7'd1;
  endfunction
endpackage

// File: rtl/can_frame_tracker_if.sv
// can_frame_tracker_if: sampled bus bit in, frame-tracking status out
interface can_frame_tracker_if;
  import can_pkg::*;
  logic       RX;
  logic       EOF_Flag;
  logic       frame_active;
  field_e     field;
  logic       rx_bit;
  logic       rx_bit_valid;
  logic [3:0] dlc;
  logic       stuff_error;
  logic       form_error;
  modport master (
    output RX,
    input  EOF_Flag, frame_active, field, rx_bit, rx_bit_valid, dlc, stuff_error, form_error
  );
  modport slave (
    input  RX,
    output EOF_Flag, frame_active, field, rx_bit, rx_bit_valid, dlc, stuff_error, form_error
  );
endinterface

// File: rtl/can_bit_destuff.sv
// can_bit_destuff: run-length tracker that flags stuff bits and stuff errors in the stuffed region
module can_bit_destuff (
  input  logic SP,
  input  logic reset,
  input  logic RX,
  input  logic enable,
  input  logic restart,
  output logic is_stuff,
  output logic stuff_error
);
  logic [2:0] r_run;
  logic       r_prev;
  assign is_stuff    = enable && r_run == 3'd5;
  assign stuff_error = is_stuff && RX == r_prev;
  always_ff @(posedge SP)
    if (!reset) begin
      r_run  <= '0;
      r_prev <= 1'b0;
    end else if (restart) begin
      r_run  <= 3'd1;
      r_prev <= 1'b0;
    end else if (enable) begin
      r_run  <= (is_stuff || RX != r_prev) ? 3'd1 : r_run + 3'd1;
      r_prev <= RX;
    end
endmodule

// File: rtl/can_frame_tracker.sv
// can_frame_tracker: CAN 2.0 field sequencer with destuffing and EOF window; CAN_EXT_ID_EN enables 29-bit IDs
module can_frame_tracker
  import can_pkg::*;
#(
  parameter int IDLE_BITS = 11
) (
  input logic SP,
  input logic reset,
  can_frame_tracker_if.slave bus
);
  localparam int IW = $clog2(IDLE_BITS + 1);
  field_e        r_field, w_field;
  logic [6:0]    r_cnt, w_cnt_inc, w_data_bits;
  logic [IW-1:0] r_idle;
  logic [3:0]    r_dlc, w_dlc_new;
  logic [2:0]    r_dlc_sr;
  logic          r_rtr, r_eof_n, r_active, r_rx_bit, r_valid, r_stuff_err, r_form_err;
  logic          w_stuffed, w_restart, w_is_stuff, w_stuff_err, w_last, w_idle_done;
  logic          w_valid, w_ide_err, w_form;
  can_bit_destuff u_destuff (
    .SP(SP), .reset(reset), .RX(bus.RX), .enable(w_stuffed), .restart(w_restart),
    .is_stuff(w_is_stuff), .stuff_error(w_stuff_err)
  );
  // CRC_DEL stays in the stuffed region so a stuff bit owed after the last CRC bit is still checked
  assign w_stuffed   = r_field >= ID_A && r_field <= CRC_DEL;
  assign w_restart   = r_field == IDLE && !bus.RX;
  assign w_cnt_inc   = r_cnt + 7'd1;
  assign w_data_bits = r_rtr ? 7'd0 : r_dlc[3] ? 7'(MAX_DATA_BITS) : {1'b0, r_dlc[2:0], 3'b000};
  assign w_last      = w_cnt_inc == field_len(r_field, w_data_bits);
  assign w_dlc_new   = {r_dlc_sr, bus.RX};
  assign w_idle_done = bus.RX && r_idle == IW'(IDLE_BITS - 1);
  assign w_valid     = w_restart || (r_field >= ID_A && r_field <= CRC && !w_is_stuff);
`ifdef CAN_EXT_ID_EN
  assign w_ide_err   = 1'b0;
`else
  assign w_ide_err   = r_field == IDE && bus.RX;
`endif
  assign w_form      = !w_is_stuff && (w_ide_err || (!bus.RX && (r_field == CRC_DEL || r_field == ACK_DEL)));
  always_comb begin
    w_field = r_field;
    if (w_stuff_err)
      w_field = WAIT_IDLE;
    else if (!w_is_stuff)
      unique case (r_field)
        WAIT_IDLE:    w_field = w_idle_done ? IDLE : WAIT_IDLE;
        IDLE:         w_field = bus.RX ? IDLE : ID_A;
        ID_A:         w_field = w_last ? SRR_RTR : ID_A;
        SRR_RTR:      w_field = IDE;
`ifdef CAN_EXT_ID_EN
        IDE:          w_field = bus.RX ? ID_B : R0;
        ID_B:         w_field = w_last ? RTR_EXT : ID_B;
        RTR_EXT:      w_field = R1;
        R1:           w_field = R0;
`else
        IDE:          w_field = bus.RX ? WAIT_IDLE : R0;
`endif
        R0:           w_field = DLC;
        DLC:          w_field = !w_last ? DLC : (r_rtr || w_dlc_new == 4'd0) ? CRC : DATA;
        DATA:         w_field = w_last ? CRC : DATA;
        CRC:          w_field = w_last ? CRC_DEL : CRC;
        CRC_DEL:      w_field = bus.RX ? ACK : WAIT_IDLE;
        ACK:          w_field = ACK_DEL;
        ACK_DEL:      w_field = bus.RX ? EOF : WAIT_IDLE;
        EOF:          w_field = !bus.RX ? WAIT_IDLE : w_last ? INTERMISSION : EOF;
        INTERMISSION: w_field = !bus.RX ? WAIT_IDLE : w_last ? IDLE : INTERMISSION;
        default:      w_field = WAIT_IDLE;
      endcase
  end
  always_ff @(posedge SP)
    if (!reset) begin
      r_field     <= WAIT_IDLE;
      r_cnt       <= '0;
      r_idle      <= '0;
      r_dlc_sr    <= '0;
      r_dlc       <= '0;
      r_rtr       <= 1'b0;
      r_eof_n     <= 1'b1;
      r_active    <= 1'b0;
      r_rx_bit    <= 1'b0;
      r_valid     <= 1'b0;
      r_stuff_err <= 1'b0;
      r_form_err  <= 1'b0;
    end else begin
      r_field     <= w_field;
      r_cnt       <= (w_field != r_field || r_field == WAIT_IDLE || r_field == IDLE) ? '0 :
                     w_is_stuff ? r_cnt : w_cnt_inc;
      r_idle      <= (r_field == WAIT_IDLE && bus.RX && !w_idle_done) ? r_idle + 1'b1 : '0;
      // a dominant EOF bit leaves the window low one more SP so the EOF checker sees it
      r_eof_n     <= !(w_field == EOF || (r_field == EOF && !bus.RX));
      r_active    <= w_field >= ID_A && w_field <= EOF;
      r_valid     <= w_valid;
      r_stuff_err <= w_stuff_err;
      r_form_err  <= w_form;
      if (w_valid)
        r_rx_bit <= bus.RX;
      if (!w_is_stuff && (r_field == SRR_RTR || r_field == RTR_EXT))
        r_rtr <= bus.RX;
      if (r_field == DLC && !w_is_stuff) begin
        r_dlc_sr <= w_dlc_new[2:0];
        if (w_last)
          r_dlc <= w_dlc_new;
      end
    end
  assign bus.EOF_Flag     = r_eof_n;
  assign bus.frame_active = r_active;
  assign bus.field        = r_field;
  assign bus.rx_bit       = r_rx_bit;
  assign bus.rx_bit_valid = r_valid;
  assign bus.dlc          = r_dlc;
  assign bus.stuff_error  = r_stuff_err;
  assign bus.form_error   = r_form_err;
endmodule

// File: tb/tb_can_frame_tracker.sv
// tb_can_frame_tracker: directed frame-level bench with bench-built stuffed frames and CRC
module tb_can_frame_tracker;
  import can_pkg::*;
  logic SP = 1'b0;
  logic reset = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  int n_valid, n_data, n_crc, n_eof_low, n_eof_pos, n_active, n_rx_bad, n_stuff, n_form, ack_idx;
  logic raw[$];
  logic tx[$];
  can_frame_tracker_if bus ();
  can_frame_tracker #(.IDLE_BITS(11)) dut (.SP(SP), .reset(reset), .bus(bus.slave));
  always #5 SP = ~SP;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input logic b);
    @(negedge SP);
    bus.RX = b;
    @(posedge SP);
    #1;
  endtask
  task automatic push(input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) raw.push_back(v[i]);
  endtask
  task automatic build(input logic ext, input logic [28:0] id, input logic rtr, input logic [3:0] dlc,
                       input int nbytes, input logic [63:0] data);
    logic [14:0] crc;
    logic nb, prev;
    int run;
    raw = {};
    tx = {};
    push(64'd0, 1);
    if (ext) begin
      push(64'(id[28:18]), 11);
      push(64'd1, 1);
      push(64'd1, 1);
      push(64'(id[17:0]), 18);
      push(64'(rtr), 1);
      push(64'd0, 2);
    end else begin
      push(64'(id[10:0]), 11);
      push(64'(rtr), 1);
      push(64'd0, 2);
    end
    push(64'(dlc), 4);
    push(data, 8 * nbytes);
    crc = '0;
    foreach (raw[i]) begin
      nb = raw[i] ^ crc[14];
      crc = {crc[13:0], 1'b0} ^ (nb ? 15'h4599 : 15'h0);
    end
    push(64'(crc), 15);
    prev = 1'b1;
    run = 0;
    foreach (raw[i]) begin
      tx.push_back(raw[i]);
      if (run > 0 && raw[i] == prev) run++;
      else begin
        run = 1;
        prev = raw[i];
      end
      if (run == 5) begin
        tx.push_back(!prev);
        prev = !prev;
        run = 1;
      end
    end
    tx.push_back(1'b1);
    tx.push_back(1'b0);
    repeat (11) tx.push_back(1'b1);
    ack_idx = tx.size() - 11;
  endtask
  task automatic send(input int nmax, input int stop_valid);
    field_e f_pre;
    n_valid = 0; n_data = 0; n_crc = 0; n_eof_low = 0; n_eof_pos = 0;
    n_active = 0; n_rx_bad = 0; n_stuff = 0; n_form = 0;
    for (int i = 0; i < nmax; i++) begin
      f_pre = bus.field;
      tick(tx[i]);
      if (bus.rx_bit_valid) begin
        if (n_valid >= raw.size() || bus.rx_bit !== raw[n_valid]) n_rx_bad++;
        if (f_pre == DATA) n_data++;
        if (f_pre == CRC) n_crc++;
        n_valid++;
      end
      if (!bus.EOF_Flag) n_eof_low++;
      if (!bus.EOF_Flag != (i >= ack_idx && i < ack_idx + 7)) n_eof_pos++;
      if (bus.frame_active) n_active++;
      if (bus.stuff_error) n_stuff++;
      if (bus.form_error) n_form++;
      if (stop_valid != 0 && n_valid == stop_valid) break;
    end
  endtask
  initial begin
    bus.RX = 1'b1;
    tick(1'b1);
    tick(1'b1);
    chk("rst_eof_flag", bus.EOF_Flag, 1);
    chk("rst_active", bus.frame_active, 0);
    chk("rst_field", bus.field, WAIT_IDLE);
    chk("rst_dlc", bus.dlc, 0);
    chk("rst_rx_bit", bus.rx_bit, 0);
    chk("rst_valid", bus.rx_bit_valid, 0);
    chk("rst_stuff", bus.stuff_error, 0);
    chk("rst_form", bus.form_error, 0);
    reset = 1'b1;
    repeat (10) tick(1'b1);
    chk("idle_after_10", bus.field, WAIT_IDLE);
    tick(1'b1);
    chk("idle_after_11", bus.field, IDLE);
    build(1'b0, 29'h123, 1'b0, 4'd1, 1, 64'h55);
    send(tx.size(), 0);
    chk("std_valid", n_valid, 42);
    chk("std_rx_bits", n_rx_bad, 0);
    chk("std_dlc", bus.dlc, 1);
    chk("std_data", n_data, 8);
    chk("std_crc", n_crc, 15);
    chk("std_eof_low", n_eof_low, 7);
    chk("std_eof_pos", n_eof_pos, 0);
    chk("std_active", n_active, tx.size() - 4);
    chk("std_errors", n_stuff + n_form, 0);
    chk("std_idle", bus.field, IDLE);
    tick(1'b0);
    chk("sof_active", bus.frame_active, 1);
    chk("sof_field", bus.field, ID_A);
    chk("sof_valid", bus.rx_bit_valid, 1);
    repeat (4) tick(1'b0);
    chk("stuff_id4", bus.stuff_error, 0);
    tick(1'b0);
    chk("stuff_id5", bus.stuff_error, 1);
    chk("stuff_active", bus.frame_active, 0);
    chk("stuff_field", bus.field, WAIT_IDLE);
    tick(1'b0);
    chk("stuff_pulse", bus.stuff_error, 0);
    repeat (5) tick(1'b1);
    tick(1'b0);
    chk("stuff_no_sof", bus.field, WAIT_IDLE);
    chk("stuff_no_active", bus.frame_active, 0);
    repeat (11) tick(1'b1);
    chk("stuff_recover", bus.field, IDLE);
    build(1'b0, 29'h7A5, 1'b0, 4'd15, 8, 64'h0123456789ABCDEF);
    send(tx.size(), 0);
    chk("dlc15_data", n_data, 64);
    chk("dlc15_dlc", bus.dlc, 15);
    chk("dlc15_valid", n_valid, 98);
    chk("dlc15_rx_bits", n_rx_bad, 0);
    chk("dlc15_idle", bus.field, IDLE);
    build(1'b0, 29'h0F0, 1'b1, 4'd4, 0, 64'h0);
    send(tx.size(), 0);
    chk("rtr_data", n_data, 0);
    chk("rtr_crc", n_crc, 15);
    chk("rtr_valid", n_valid, 34);
    chk("rtr_dlc", bus.dlc, 4);
    chk("rtr_eof_low", n_eof_low, 7);
    build(1'b0, 29'h2AA, 1'b0, 4'd2, 2, 64'hBEEF);
    tx[ack_idx] = 1'b0;
    send(ack_idx + 1, 0);
    chk("ackdel_form", bus.form_error, 1);
    chk("ackdel_eof_flag", bus.EOF_Flag, 1);
    chk("ackdel_field", bus.field, WAIT_IDLE);
    chk("ackdel_active", bus.frame_active, 0);
    tick(1'b1);
    chk("ackdel_pulse", bus.form_error, 0);
    repeat (10) tick(1'b1);
    chk("ackdel_recover", bus.field, IDLE);
    build(1'b0, 29'h555, 1'b0, 4'd1, 1, 64'hA0);
    tx[ack_idx + 3] = 1'b0;
    send(ack_idx + 4, 0);
    chk("eof3_flag", bus.EOF_Flag, 0);
    chk("eof3_form", bus.form_error, 0);
    chk("eof3_form_seen", n_form, 0);
    chk("eof3_field", bus.field, WAIT_IDLE);
    tick(1'b1);
    chk("eof3_flag_after", bus.EOF_Flag, 1);
    repeat (10) tick(1'b1);
    chk("eof3_recover", bus.field, IDLE);
    build(1'b0, 29'h1C3, 1'b0, 4'd15, 8, 64'hFEDCBA9876543210);
    send(tx.size(), 28);
    chk("rst_mid_data9", n_data, 9);
    reset = 1'b0;
    tick(1'b0);
    chk("rst_mid_field", bus.field, WAIT_IDLE);
    chk("rst_mid_active", bus.frame_active, 0);
    chk("rst_mid_eof_flag", bus.EOF_Flag, 1);
    chk("rst_mid_valid", bus.rx_bit_valid, 0);
    chk("rst_mid_dlc", bus.dlc, 0);
    chk("rst_mid_stuff", bus.stuff_error, 0);
    chk("rst_mid_form", bus.form_error, 0);
    reset = 1'b1;
    repeat (10) tick(1'b1);
    tick(1'b0);
    chk("rst_mid_no_sof", bus.field, WAIT_IDLE);
    repeat (11) tick(1'b1);
    chk("rst_mid_idle", bus.field, IDLE);
`ifdef CAN_EXT_ID_EN
    build(1'b1, 29'h12345678, 1'b0, 4'd2, 2, 64'hC3A5);
    send(tx.size(), 0);
    chk("ext_valid", n_valid, 70);
    chk("ext_rx_bits", n_rx_bad, 0);
    chk("ext_dlc", bus.dlc, 2);
    chk("ext_eof_low", n_eof_low, 7);
    chk("ext_idle", bus.field, IDLE);
`else
    build(1'b1, 29'h12345678, 1'b0, 4'd2, 2, 64'hC3A5);
    send(tx.size(), 14);
    chk("ide_form", bus.form_error, 1);
    chk("ide_field", bus.field, WAIT_IDLE);
    chk("ide_active", bus.frame_active, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
